// File: rtl/mips_register_file_mp.sv
// Multi-port general-purpose register file for the MIPS-compatible core.
// Two write ports (A: ALU writeback, B: late load return), NUM_READ
// combinational read ports with optional same-cycle write forwarding,
// HI/LO multiply/divide registers and a per-register load-pending scoreboard.
module mips_register_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int BYPASS     = 1,
  parameter int DEBUG_REG  = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]   read_reg,
  output logic [NUM_READ*DATA_WIDTH-1:0]   read_data,
  output logic [NUM_READ-1:0]              read_pending,
  input  logic                             write_enable_a,
  input  logic [ADDR_WIDTH-1:0]            write_reg_a,
  input  logic [DATA_WIDTH-1:0]            write_data_a,
  input  logic                             write_enable_b,
  input  logic [ADDR_WIDTH-1:0]            write_reg_b,
  input  logic [DATA_WIDTH-1:0]            write_data_b,
  input  logic                             reserve_enable,
  input  logic [ADDR_WIDTH-1:0]            reserve_reg,
  input  logic                             hilo_write_enable,
  input  logic [DATA_WIDTH-1:0]            hi_write_data,
  input  logic [DATA_WIDTH-1:0]            lo_write_data,
  output logic [DATA_WIDTH-1:0]            hi_data,
  output logic [DATA_WIDTH-1:0]            lo_data,
  output logic [DATA_WIDTH-1:0]            read_data_debug
);

  localparam int                     DEPTH   = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0]  DBG_IDX = ADDR_WIDTH'(DEBUG_REG);
  localparam bit                     BYP     = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]      r_pending;
  logic [DEPTH-1:0]      w_pending_next;
  logic [DATA_WIDTH-1:0] r_hi;
  logic [DATA_WIDTH-1:0] r_lo;

  // Writes to register 0 are dropped here so it stays hard-wired to zero.
  logic w_wr_a;
  logic w_wr_b;
  assign w_wr_a = write_enable_a && (write_reg_a != '0);
  assign w_wr_b = write_enable_b && (write_reg_b != '0);

  // Register array update; port A is applied last so it wins a same-index collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_regs[k] <= '0;
      end
    end else begin
      if (w_wr_b) r_regs[write_reg_b] <= write_data_b;
      if (w_wr_a) r_regs[write_reg_a] <= write_data_a;
    end
  end

  // Scoreboard next state: load return clears, a new reserve sets (reserve wins).
  always_comb begin
    w_pending_next = r_pending;
    if (w_wr_b)         w_pending_next[write_reg_b] = 1'b0;
    if (reserve_enable) w_pending_next[reserve_reg] = 1'b1;
    w_pending_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) r_pending <= '0;
    else       r_pending <= w_pending_next;
  end

  // HI/LO pair, always written together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (hilo_write_enable) begin
      r_hi <= hi_write_data;
      r_lo <= lo_write_data;
    end
  end

  assign hi_data         = r_hi;
  assign lo_data         = r_lo;
  assign read_data_debug = r_regs[DBG_IDX];

  // Independent read ports; forwarding priority A over B mirrors the write collision rule.
  for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_hit_a;
    logic                  w_hit_b;
    assign w_idx   = read_reg[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_hit_a = BYP && w_wr_a && (write_reg_a == w_idx);
    assign w_hit_b = BYP && w_wr_b && (write_reg_b == w_idx);
    assign read_data[g*DATA_WIDTH +: DATA_WIDTH] =
      (w_idx == '0) ? '0 :
      w_hit_a       ? write_data_a :
      w_hit_b       ? write_data_b :
                      r_regs[w_idx];
    assign read_pending[g] = w_hit_b ? 1'b0 : r_pending[w_idx];
  end

endmodule

// File: doc/mips_register_file_mp.md
# mips_register_file_mp

Parametrised multi-port general-purpose register file for the MIPS-compatible core. It supersedes the fixed 2-read/1-write register file and sits between decode (operand reads) and writeback (ALU and load results). It adds a configurable number of read ports and a second write port for late load returns. It also adds an optional same-cycle write-to-read bypass, HI/LO registers for multiply/divide, and a per-register pending scoreboard for load-use hazard detection.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
- NUM_READ, 2, number of read ports (1..4)
- BYPASS, 1, 1 = a write in the current cycle is forwarded to reads of the same register; 0 = reads show stored state only
- DEBUG_REG, 2, index driven on read_data_debug (2 = $v0)

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- read_reg  in  NUM_READ*ADDR_WIDTH  packed read indices; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- read_data  out  NUM_READ*DATA_WIDTH  packed read data, same packing
- read_pending  out  NUM_READ  bit i = register addressed by port i awaits a load return
- write_enable_a  in  1  port A (ALU writeback) enable
- write_reg_a  in  ADDR_WIDTH  port A index
- write_data_a  in  DATA_WIDTH  port A data
- write_enable_b  in  1  port B (load return) enable
- write_reg_b  in  ADDR_WIDTH  port B index
- write_data_b  in  DATA_WIDTH  port B data
- reserve_enable  in  1  mark reserve_reg pending (load issued)
- reserve_reg  in  ADDR_WIDTH  register to reserve
- hilo_write_enable  in  1  load HI and LO
- hi_write_data, lo_write_data  in  DATA_WIDTH each  HI/LO next values
- hi_data, lo_data  out  DATA_WIDTH each  current HI/LO
- read_data_debug  out  DATA_WIDTH  stored value of DEBUG_REG, never bypassed

## Operation
- Register 0: always reads 0; writes to it are discarded; it can never be pending; reserving it has no effect.
- Writes: the addressed register is updated on the rising edge when its enable is high. If A and B target the same nonzero register in one cycle, port A's data is stored.
- Scoreboard: one pending bit per register.
  - reserve_enable sets the bit for reserve_reg.
  - A port-B write clears the bit for write_reg_b.
  - A port-A write does not touch pending bits.
  - If reserve and a port-B clear hit the same register in one cycle, the bit ends set.
- Read path per port, combinational:
  - index 0 gives 0;
  - else, if BYPASS=1 and port A writes that index this cycle, gives write_data_a;
  - else, if BYPASS=1 and port B writes that index, gives write_data_b;
  - else gives the stored value.
- read_pending per port: the stored bit for that index. If BYPASS=1 and port B writes that index this cycle, it reads 0.
- HI/LO: both are updated together on the edge when hilo_write_enable is high. There is no bypass; hi_data/lo_data show stored values.
- Reset: all registers, HI, LO and pending bits go to 0. Reset overrides all writes and reserves in the same cycle.

## Timing
- Write latency: data is stored at the edge. Without bypass, it is visible on read_data from the next cycle. With BYPASS=1, it is visible in the same cycle.
- Pending: set at the edge after reserve_enable; visible on read_pending the following cycle. It is cleared at the edge of the port-B write, and also in the same cycle when BYPASS=1.
- All outputs are combinational from stored state plus bypass inputs. There are no output registers.
- Reset values, from the first edge with reset high: read_data 0 (when bypass is inactive), read_pending 0, hi_data 0, lo_data 0, read_data_debug 0.
- Reset asserted while a register is pending: the bit is cleared. A port-B write arriving after reset simply writes, with no error.
- Every read port is independent. Any number of ports may address the same register.

## Test plan
- Reset, then read all 32 indices on every port -> all 0. Write A reg 5 = 0xDEADBEEF, then write A reg 0 = 0x12345678 -> next cycle reg 5 = 0xDEADBEEF and reg 0 = 0.
- BYPASS=1: write A reg 7 = 0xA5A5A5A5 while port 0 reads reg 7 -> same cycle 0xA5A5A5A5. With BYPASS=0 -> old value, then 0xA5A5A5A5 next cycle.
- Simultaneous A and B to reg 9 (0x1111 / 0x2222) -> reg 9 = 0x1111, and reg 9's pending bit is cleared.
- Reserve reg 8 -> read_pending=1 from the next cycle. Port B writes reg 8 = 0x55 -> pending 0 (same cycle if BYPASS=1), data 0x55.
- Reserve and port-B clear of reg 3 in the same cycle -> pending stays 1. Reserve reg 0 -> pending never asserts.
- HI/LO written 0xFFFF0000 / 0x0000FFFF, $v0 written 0x42, then reset asserted with a simultaneous write A reg 2 = 0x99 -> after the edge hi_data=lo_data=0, read_data_debug=0, pending all 0.
